word_serializer: RTL and testbench

WORD_SERIALIZER -- requirements
Module: word_serializer

---
 rtl/word_serializer.sv | 108 ++++++++++
 tb/tb_word_serializer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_serializer.sv
// Word serializer: a DEPTH-entry FIFO of 16-bit words feeding a tick-paced
// serial shifter. Each word goes out as 16 data bits followed by one idle gap tick.
module word_serializer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [15:0]              in_data,
    output logic                     in_ready,
    input  logic                     msb_first,
    input  logic                     tick,
    output logic                     ser_out,
    output logic                     ser_valid,
    output logic                     frame,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t         state, state_nx;
    logic [15:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [15:0]    shifter;
    logic           msb_lat;
    logic [3:0]     bit_cnt;
    logic           push, pop;

    assign in_ready = (fifo_count < FULL) && !rst;
    assign push     = in_valid && in_ready;
    // Pop looks only at the count held at cycle start, so a word pushed
    // into an empty FIFO is visible to the FSM one cycle later.
    assign pop      = (state == IDLE) && (fifo_count != '0);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (fifo_count != '0) state_nx = SHIFT;
            SHIFT:   if (tick && bit_cnt == 4'd15) state_nx = GAP;
            GAP:     if (tick) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Shift toward whichever end drives the line for this word.
    always_ff @(posedge clk) begin
        if (rst) begin
            shifter <= '0;
            msb_lat <= 1'b0;
            bit_cnt <= '0;
        end else if (pop) begin
            shifter <= mem[rd_ptr];
            msb_lat <= msb_first;
            bit_cnt <= '0;
        end else if (state == SHIFT && tick && bit_cnt != 4'd15) begin
            shifter <= msb_lat ? {shifter[14:0], 1'b0} : {1'b0, shifter[15:1]};
            bit_cnt <= bit_cnt + 4'd1;
        end
    end

    always_comb begin
        ser_out   = 1'b1;
        ser_valid = 1'b0;
        frame     = 1'b0;
        if (state == SHIFT) begin
            ser_out   = msb_lat ? shifter[15] : shifter[0];
            ser_valid = 1'b1;
            frame     = (bit_cnt == 4'd0);
        end
    end

    assign busy = (state != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: directed timing cases plus random traffic, with
// a word-level scoreboard rebuilding each serial word from tick-sampled bits.
module tb_word_serializer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, in_valid, msb_first, tick;
    logic [15:0] in_data;
    logic        in_ready, ser_out, ser_valid, frame, busy;
    logic [$clog2(DEPTH):0] fifo_count;

    int checks = 0;
    int failures = 0;
    int words_seen = 0;

    logic [16:0] q[$];
    logic [15:0] sv;
    int          nbits = 0;

    word_serializer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .msb_first(msb_first), .tick(tick),
        .ser_out(ser_out), .ser_valid(ser_valid), .frame(frame),
        .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rev16(input logic [15:0] w);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = w[15-i];
        return r;
    endfunction

    // Scoreboard: words enter on accepted pushes, one bit is taken per
    // ser_valid&tick cycle, first-sent bit lands in sv[15].
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            nbits = 0;
        end else begin
            logic [16:0] e;
            logic [15:0] expw;
            chk("in_ready_rule", in_ready, fifo_count < DEPTH);
            chk("count_bound", fifo_count <= DEPTH, 1);
            if (!ser_valid) chk("idle_line", {ser_out, frame}, 2'b10);
            if (in_valid && in_ready) q.push_back({msb_first, in_data});
            if (ser_valid && tick) begin
                chk("frame_pos", frame, nbits == 0);
                sv = {sv[14:0], ser_out};
                nbits++;
                if (nbits == 16) begin
                    nbits = 0;
                    if (q.size() == 0) chk("spurious_word", 1, 0);
                    else begin
                        e = q.pop_front();
                        expw = e[16] ? e[15:0] : rev16(e[15:0]);
                        chk("word", sv, expw);
                        words_seen++;
                    end
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        int n;
        step();
        in_valid = 1'b0;
        tick = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 400);
        chk("drain_busy", busy, 0);
        chk("sb_empty", q.size(), 0);
    endtask

    task automatic one_word(input logic msb, input logic [15:0] expv);
        int n;
        logic [15:0] v;
        step();
        tick = 1'b1;
        msb_first = msb;
        in_valid = 1'b1;
        in_data = 16'hA5C3;
        @(negedge clk);
        step();
        in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ser_valid && n < 20);
        chk("latency", n, 2);
        chk("frame_first", frame, 1);
        v[15] = ser_out;
        msb_first = ~msb;
        for (int i = 14; i >= 0; i--) begin
            @(negedge clk);
            chk("bit_valid", ser_valid, 1);
            chk("frame_rest", frame, 0);
            v[i] = ser_out;
        end
        chk("bits", v, expv);
        @(negedge clk);
        chk("gap", {ser_valid, ser_out, busy}, 3'b011);
        @(negedge clk);
        chk("back_idle", {ser_valid, busy}, 2'b00);
        msb_first = msb;
    endtask

    task automatic slow_tick;
        int n, c, tot, nv;
        step();
        tick = 1'b0;
        msb_first = 1'b1;
        in_valid = 1'b1;
        in_data = 16'($urandom);
        step();
        in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ser_valid && n < 20);
        c = 0; tot = 0; nv = 0;
        while (busy && c < 100) begin
            tot++;
            nv += int'(ser_valid);
            @(posedge clk);
            #1;
            c++;
            tick = (c % 3 == 2);
            @(negedge clk);
        end
        chk("span_51", tot, 51);
        chk("valid_48", nv, 48);
        tick = 1'b1;
    endtask

    task automatic overflow;
        int n, idx, sawfull, w0;
        logic [15:0] w[5];
        w0 = words_seen;
        for (int i = 0; i < 5; i++) w[i] = 16'($urandom);
        step();
        tick = 1'b1;
        msb_first = 1'b0;
        in_valid = 1'b1;
        in_data = 16'($urandom);
        step();
        in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ser_valid && n < 20);
        idx = 0; sawfull = 0; n = 0;
        while (idx < 5 && n < 200) begin
            step();
            in_valid = 1'b1;
            in_data = w[idx];
            @(negedge clk);
            if (!in_ready) begin
                if (sawfull == 0) chk("full_count", fifo_count, 4);
                sawfull = 1;
            end else idx++;
            n++;
        end
        chk("all_pushed", idx, 5);
        chk("stalled", sawfull, 1);
        drain();
        chk("six_words", words_seen - w0, 6);
    endtask

    task automatic push_pop;
        int n;
        step();
        tick = 1'b0;
        msb_first = 1'b1;
        in_valid = 1'b1;
        in_data = 16'($urandom);
        step();
        in_valid = 1'b0;
        repeat (3) step();
        in_valid = 1'b1;
        in_data = 16'($urandom);
        step();
        in_data = 16'($urandom);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("pp_setup", fifo_count, 2);
        step();
        tick = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ser_valid && n < 40);
        step();
        in_valid = 1'b1;
        in_data = 16'($urandom);
        @(negedge clk);
        chk("pp_pre", fifo_count, 2);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("pp_post", fifo_count, 2);
        chk("pp_shift", ser_valid, 1);
        drain();
    endtask

    task automatic mid_reset;
        int n, bad;
        step();
        tick = 1'b1;
        msb_first = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data = 16'($urandom);
            step();
        end
        in_valid = 1'b0;
        n = 0;
        bad = 0;
        while (n < 7 && bad < 40) begin
            @(negedge clk);
            if (ser_valid) n++;
            bad++;
        end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_outs", {ser_valid, ser_out, frame, busy}, 4'b0100);
        chk("rst_count", fifo_count, 0);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            bad += int'(ser_valid);
        end
        chk("rst_no_bits", bad, 0);
    endtask

    task automatic random_phase(input int tp);
        step();
        msb_first = 1'($urandom);
        repeat (250) begin
            tick = ($urandom_range(0, 99) < tp);
            in_valid = 1'($urandom);
            in_data = 16'($urandom);
            step();
        end
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 16'hFFFF;
        msb_first = 1'b0;
        tick = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ready_in_rst", in_ready, 0);
        chk("rst_state", {ser_valid, ser_out, frame, busy}, 4'b0100);
        chk("rst_cnt", fifo_count, 0);
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1);

        one_word(1'b1, 16'hA5C3);
        one_word(1'b0, 16'hC3A5);
        slow_tick();
        overflow();
        push_pop();
        mid_reset();
        random_phase(100);
        random_phase(30);
        random_phase(5);
        random_phase(60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
